bos: RTL and testbench

BOS -- requirements
Module: bos

---
 rtl/bos.sv | 246 ++++++++++++++++++++++++
 tb/tb_bos.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bos.sv
// BOS: UART packet router. Frames of DD src dst len payload crc are routed to
// per-destination strobes; destination 0 feeds a 24-bit SPI DAC through a 4-word FIFO.
`timescale 1ns/1ps
module bos #(
  parameter int N_SRC     = 4,
  parameter int BAUD_DIV  = 434,
  parameter int TIMEOUT_W = 20
) (
  input  logic             fpga_clk_48,
  input  logic             n_rst,
  input  logic             rx,
  output logic             tx,
  output logic             dac_din,
  output logic             dac_sclk,
  output logic             dac_sync_n,
  input  logic             dac_sdo,
  input  logic             dac_rdy,
  output logic             dac_rst_n,
  output logic             din_power,
  output logic             sclk_power,
  output logic             rst_power_n,
  output logic             sync_core_n,
  output logic             sync_digital_n,
  output logic             sync_vpr_digital_n,
  output logic             adc_sclk_pwr,
  output logic             adc_din_pwr,
  input  logic             adc_dout_pwr,
  output logic             adc_cs_pwr_n,
  output logic [7:0]       my_rx_data,
  output logic             my_rx_valid,
  output logic [7:0]       my_master_data,
  output logic [N_SRC-1:0] my_valid_bus,
  output logic [7:0]       my_tx_data,
  output logic             my_tx_valid
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] BIT_END  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_END = BW'(BAUD_DIV / 2 - 1);

  localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3, RX_WAIT = 3'd4;
  localparam logic [2:0] P_IDLE = 3'd0, P_SRC = 3'd1, P_DST = 3'd2, P_LEN = 3'd3, P_DATA = 3'd4, P_CRC = 3'd5;
  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2;

  logic          rx_meta, rx_q, rx_prev;
  logic [2:0]    rx_state, rx_bit;
  logic [BW-1:0] rx_cnt;
  logic [7:0]    rx_sh;

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge fpga_clk_48) begin
    if (n_rst) begin
      rx_meta <= 1'b1; rx_q <= 1'b1; rx_prev <= 1'b1;
      rx_state <= RX_IDLE; rx_bit <= '0; rx_cnt <= '0; rx_sh <= '0;
      my_rx_data <= '0; my_rx_valid <= 1'b0;
    end else begin
      rx_meta <= rx; rx_q <= rx_meta; rx_prev <= rx_q;
      my_rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_q) rx_state <= RX_START;
        end
        RX_START:
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0; rx_bit <= '0;
            rx_state <= rx_q ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + BW'(1);
        RX_DATA:
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_q, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else rx_cnt <= rx_cnt + BW'(1);
        RX_STOP:
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            if (rx_q) begin
              my_rx_data <= rx_sh; my_rx_valid <= 1'b1; rx_state <= RX_IDLE;
            end else rx_state <= RX_WAIT;
          end else rx_cnt <= rx_cnt + BW'(1);
        default: if (rx_q) rx_state <= RX_IDLE;  // framing error: wait for line idle
      endcase
    end
  end

  logic [2:0]           p_state;
  logic [7:0]           src_id, dst_id, pkt_len, data_cnt, sum;
  logic [TIMEOUT_W-1:0] idle_cnt;
  logic                 st_req;
  logic [7:0]           st_byte;

  always_ff @(posedge fpga_clk_48) begin
    if (n_rst) begin
      p_state <= P_IDLE; src_id <= '0; dst_id <= '0; pkt_len <= '0; data_cnt <= '0;
      sum <= '0; idle_cnt <= '0; st_req <= 1'b0; st_byte <= '0;
      my_master_data <= '0; my_valid_bus <= '0;
    end else begin
      st_req <= 1'b0;
      my_valid_bus <= '0;
      if (p_state == P_IDLE || my_rx_valid) idle_cnt <= '0;
      else idle_cnt <= idle_cnt + TIMEOUT_W'(1);
      if (my_rx_valid) begin
        case (p_state)
          P_IDLE: if (my_rx_data == 8'hDD) p_state <= P_SRC;
          P_SRC:  begin src_id <= my_rx_data; p_state <= P_DST; end
          P_DST:  begin dst_id <= my_rx_data; p_state <= P_LEN; end
          P_LEN: begin
            pkt_len <= my_rx_data; data_cnt <= '0; sum <= '0;
            p_state <= (my_rx_data == 8'd0) ? P_CRC : P_DATA;
          end
          P_DATA: begin
            my_master_data <= my_rx_data;
            sum <= sum + my_rx_data;
            for (int i = 0; i < N_SRC; i++) my_valid_bus[i] <= (dst_id == 8'(i));
            data_cnt <= data_cnt + 8'd1;
            if (data_cnt == pkt_len - 8'd1) p_state <= P_CRC;
          end
          default: begin
            st_req  <= 1'b1;
            st_byte <= (my_rx_data == sum) ? 8'h00 : 8'hEE;
            p_state <= P_IDLE;
          end
        endcase
      end else if (&idle_cnt) p_state <= P_IDLE;
    end
  end

  logic          st_pend, tx_busy;
  logic [7:0]    st_hold;
  logic [9:0]    tx_sh;
  logic [3:0]    tx_bit;
  logic [BW-1:0] tx_cnt;

  assign tx = tx_sh[0];

  always_ff @(posedge fpga_clk_48) begin
    if (n_rst) begin
      st_pend <= 1'b0; st_hold <= '0; tx_busy <= 1'b0; tx_sh <= '1; tx_bit <= '0; tx_cnt <= '0;
      my_tx_data <= '0; my_tx_valid <= 1'b0;
    end else begin
      my_tx_valid <= 1'b0;
      if (st_req) begin
        st_pend <= 1'b1; st_hold <= st_byte;
      end else if (st_pend && !tx_busy) begin
        st_pend <= 1'b0; tx_busy <= 1'b1;
        tx_sh <= {1'b1, st_hold, 1'b0}; tx_cnt <= '0; tx_bit <= '0;
        my_tx_data <= st_hold; my_tx_valid <= 1'b1;
      end
      if (tx_busy) begin
        if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          tx_sh  <= {1'b1, tx_sh[9:1]};
          tx_bit <= tx_bit + 4'd1;
          if (tx_bit == 4'd9) tx_busy <= 1'b0;
        end else tx_cnt <= tx_cnt + BW'(1);
      end
    end
  end

  logic [1:0]  pk_cnt, wr_ptr, rd_ptr;
  logic [15:0] pk_sh;
  logic [2:0]  fifo_cnt;
  logic [23:0] fifo_mem [4];
  logic        push_word, pop_word;

  assign push_word = my_valid_bus[0] && (pk_cnt == 2'd2) && (fifo_cnt != 3'd4);

  // NOTE: FIFO storage is deliberately not reset; the pointers and count alone define emptiness.
  always_ff @(posedge fpga_clk_48) begin
    if (push_word) fifo_mem[wr_ptr] <= {pk_sh, my_master_data};
  end

  always_ff @(posedge fpga_clk_48) begin
    if (n_rst) begin
      pk_cnt <= '0; pk_sh <= '0; wr_ptr <= '0; rd_ptr <= '0; fifo_cnt <= '0;
    end else begin
      if (p_state == P_IDLE) pk_cnt <= '0;  // drops a partial word at packet end
      else if (my_valid_bus[0]) begin
        pk_sh  <= {pk_sh[7:0], my_master_data};
        pk_cnt <= (pk_cnt == 2'd2) ? 2'd0 : pk_cnt + 2'd1;
      end
      if (push_word) wr_ptr <= wr_ptr + 2'd1;
      if (pop_word)  rd_ptr <= rd_ptr + 2'd1;
      case ({push_word, pop_word})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  logic [1:0]  s_state, s_ph;
  logic [4:0]  s_bit;
  logic [2:0]  s_gap;
  logic [23:0] s_sh;

  assign pop_word = (s_state == S_IDLE) && (fifo_cnt != 3'd0) && dac_rdy;

  always_ff @(posedge fpga_clk_48) begin
    if (n_rst) begin
      s_state <= S_IDLE; s_ph <= '0; s_bit <= '0; s_gap <= '0; s_sh <= '0;
      dac_sync_n <= 1'b1; dac_sclk <= 1'b0; dac_din <= 1'b0; dac_rst_n <= 1'b0;
    end else begin
      dac_rst_n <= 1'b1;
      case (s_state)
        S_IDLE:
          if (pop_word) begin
            s_sh <= fifo_mem[rd_ptr]; s_ph <= '0; s_bit <= '0;
            dac_sync_n <= 1'b0; s_state <= S_SHIFT;
          end
        S_SHIFT: begin
          s_ph <= s_ph + 2'd1;
          case (s_ph)
            2'd0: begin dac_sclk <= 1'b1; dac_din <= s_sh[23]; s_sh <= {s_sh[22:0], 1'b0}; end
            2'd2: dac_sclk <= 1'b0;
            2'd3: begin
              s_bit <= s_bit + 5'd1;
              if (s_bit == 5'd23) begin
                s_state <= S_GAP; s_gap <= '0; dac_sync_n <= 1'b1; dac_din <= 1'b0;
              end
            end
            default: ;
          endcase
        end
        default: begin
          s_gap <= s_gap + 3'd1;
          if (s_gap == 3'd3) s_state <= S_IDLE;
        end
      endcase
    end
  end

  assign din_power          = 1'b0;
  assign sclk_power         = 1'b0;
  assign rst_power_n        = 1'b1;
  assign sync_core_n        = 1'b1;
  assign sync_digital_n     = 1'b1;
  assign sync_vpr_digital_n = 1'b1;
  assign adc_sclk_pwr       = 1'b0;
  assign adc_din_pwr        = 1'b0;
  assign adc_cs_pwr_n       = 1'b1;

  logic unused_ok;
  assign unused_ok = &{1'b0, dac_sdo, adc_dout_pwr, src_id};
endmodule

// File: tb/tb_bos.sv
// Self-checking bench for bos: table vectors, random packets against a packet-level model,
// and hand sequences for dac_rdy stall, FIFO overflow, timeout, framing error and reset.
`timescale 1ns/1ps
module tb_bos;
  localparam int BAUD = 8;
  localparam int NS   = 4;
  localparam int TW   = 12;

  typedef logic [7:0] byte_q_t [$];
  typedef struct { logic [7:0] dst; logic [7:0] data; } route_t;
  typedef struct { string name; logic [127:0] b; int n; logic [7:0] status; int n_routes; } vec_t;

  logic clk = 1'b0, n_rst = 1'b1, rx = 1'b1, dac_rdy = 1'b1;
  logic tx, dac_din, dac_sclk, dac_sync_n, dac_rst_n;
  logic din_power, sclk_power, rst_power_n, sync_core_n, sync_digital_n, sync_vpr_digital_n;
  logic adc_sclk_pwr, adc_din_pwr, adc_cs_pwr_n;
  logic [7:0] my_rx_data, my_master_data, my_tx_data;
  logic my_rx_valid, my_tx_valid;
  logic [NS-1:0] my_valid_bus;

  bos #(.N_SRC(NS), .BAUD_DIV(BAUD), .TIMEOUT_W(TW)) dut (
    .fpga_clk_48(clk), .n_rst(n_rst), .rx(rx), .tx(tx),
    .dac_din(dac_din), .dac_sclk(dac_sclk), .dac_sync_n(dac_sync_n), .dac_sdo(1'b0),
    .dac_rdy(dac_rdy), .dac_rst_n(dac_rst_n),
    .din_power(din_power), .sclk_power(sclk_power), .rst_power_n(rst_power_n),
    .sync_core_n(sync_core_n), .sync_digital_n(sync_digital_n), .sync_vpr_digital_n(sync_vpr_digital_n),
    .adc_sclk_pwr(adc_sclk_pwr), .adc_din_pwr(adc_din_pwr), .adc_dout_pwr(1'b1), .adc_cs_pwr_n(adc_cs_pwr_n),
    .my_rx_data(my_rx_data), .my_rx_valid(my_rx_valid), .my_master_data(my_master_data),
    .my_valid_bus(my_valid_bus), .my_tx_data(my_tx_data), .my_tx_valid(my_tx_valid)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  route_t got_routes[$], exp_routes[$];
  logic [23:0] got_words[$], exp_words[$];
  logic [7:0] got_tx[$], got_txv[$], exp_tx[$];
  int rx_pulses = 0, sync_falls = 0, spi_bits = 0, spi_bad = 0, min_gap = 1000;
  longint last_rise_t = -1;
  logic [23:0] spi_sh;
  logic [7:0] tx_b;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Output monitors
  always @(negedge clk) begin
    if (my_valid_bus != '0) begin
      route_t r;
      r.data = my_master_data;
      r.dst  = 8'hFF;
      for (int i = 0; i < NS; i++)
        if ($countones(my_valid_bus) == 1 && my_valid_bus[i]) r.dst = 8'(i);
      got_routes.push_back(r);
    end
    if (my_tx_valid) got_txv.push_back(my_tx_data);
    if (my_rx_valid) rx_pulses++;
  end

  always @(negedge dac_sync_n) begin
    spi_bits = 0;
    sync_falls++;
    if (last_rise_t >= 0 && int'(($time - last_rise_t) / 10) < min_gap)
      min_gap = int'(($time - last_rise_t) / 10);
  end
  always @(negedge dac_sclk) if (!dac_sync_n) begin spi_sh = {spi_sh[22:0], dac_din}; spi_bits++; end
  always @(posedge dac_sync_n) if (!n_rst && spi_bits > 0) begin
    last_rise_t = $time;
    if (spi_bits != 24) spi_bad++;
    got_words.push_back(spi_sh);
  end

  initial forever begin
    @(negedge tx);
    #(BAUD * 5);
    if (tx !== 1'b0) continue;
    for (int k = 0; k < 8; k++) begin #(BAUD * 10); tx_b[k] = tx; end
    #(BAUD * 10);
    got_tx.push_back(tx === 1'b1 ? tx_b : 8'h5A);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Packet-level reference: find DD frames, sum payload, route, pack DAC words per packet.
  function automatic void model(input byte_q_t s, input int fifo_cap);
    int i, n, dst, len;
    logic [7:0] sum;
    logic [7:0] pk[$];
    exp_routes.delete(); exp_words.delete(); exp_tx.delete();
    n = s.size(); i = 0;
    while (i < n) begin
      if (s[i] != 8'hDD) begin i++; continue; end
      if (i + 4 >= n) break;
      dst = int'(s[i+2]); len = int'(s[i+3]);
      if (i + 4 + len >= n) break;
      sum = 8'h00; pk.delete();
      for (int k = 0; k < len; k++) begin
        sum += s[i+4+k];
        if (dst < NS) exp_routes.push_back('{8'(dst), s[i+4+k]});
        if (dst == 0) pk.push_back(s[i+4+k]);
      end
      for (int w = 0; w + 3 <= pk.size(); w += 3)
        if (exp_words.size() < fifo_cap) exp_words.push_back({pk[w], pk[w+1], pk[w+2]});
      exp_tx.push_back(s[i+4+len] == sum ? 8'h00 : 8'hEE);
      i += 5 + len;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin rx = fr[k]; repeat (BAUD) @(negedge clk); end
    rx = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
  endtask

  task automatic clear_got();
    got_routes.delete(); got_words.delete(); got_tx.delete(); got_txv.delete();
    spi_bad = 0; sync_falls = 0;
  endtask

  task automatic send_q(input byte_q_t s);
    foreach (s[i]) send_byte(s[i], 1'b1);
  endtask

  task automatic start_pkt(input byte_q_t s, input int fifo_cap);
    clear_got();
    model(s, fifo_cap);
    send_q(s);
  endtask

  task automatic wait_status();
    for (int c = 0; c < 3000 && got_tx.size() < exp_tx.size(); c++) @(negedge clk);
  endtask

  task automatic finish_pkt(input string nm);
    wait_status();
    repeat (600) @(negedge clk);
    check({nm, " route count"}, got_routes.size(), exp_routes.size());
    for (int i = 0; i < got_routes.size() && i < exp_routes.size(); i++)
      check({nm, " route"}, {got_routes[i].dst, got_routes[i].data}, {exp_routes[i].dst, exp_routes[i].data});
    check({nm, " dac word count"}, got_words.size(), exp_words.size());
    for (int i = 0; i < got_words.size() && i < exp_words.size(); i++)
      check({nm, " dac word"}, got_words[i], exp_words[i]);
    check({nm, " status count"}, got_tx.size(), exp_tx.size());
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
      check({nm, " status byte"}, got_tx[i], exp_tx[i]);
    check({nm, " tx pulse count"}, got_txv.size(), exp_tx.size());
    for (int i = 0; i < got_txv.size() && i < exp_tx.size(); i++)
      check({nm, " my_tx_data"}, got_txv[i], exp_tx[i]);
    check({nm, " spi frame length"}, spi_bad, 0);
  endtask

  vec_t vt[4];
  byte_q_t q;
  logic [7:0] s8;

  initial begin
    vt[0] = '{"req026", 128'({8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15}), 11, 8'h00, 6};
    vt[1] = '{"req027", 128'({8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h16}), 11, 8'hEE, 6};
    vt[2] = '{"req028", 128'({8'hDD, 8'h01, 8'h07, 8'h02, 8'hAA, 8'hBB, 8'h65}), 7, 8'h00, 0};
    vt[3] = '{"req029", 128'({8'h55, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00}), 6, 8'h00, 0};

    // Reset state
    repeat (4) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset dac_sync_n", dac_sync_n, 1'b1);
    check("reset dac_rst_n", dac_rst_n, 1'b0);
    check("reset dac_sclk", dac_sclk, 1'b0);
    check("reset dac_din", dac_din, 1'b0);
    check("reset my_rx", {my_rx_valid, my_rx_data}, 9'h0);
    check("reset my_master", {my_valid_bus, my_master_data}, 12'h0);
    check("reset my_tx", {my_tx_valid, my_tx_data}, 9'h0);
    check("reserved outputs", {din_power, sclk_power, rst_power_n, sync_core_n, sync_digital_n,
                               sync_vpr_digital_n, adc_sclk_pwr, adc_din_pwr, adc_cs_pwr_n}, 9'b001111001);
    n_rst = 1'b0;
    repeat (4) @(negedge clk);
    check("dac_rst_n after reset", dac_rst_n, 1'b1);

    // Table vectors
    for (int v = 0; v < 4; v++) begin
      q.delete();
      for (int k = 0; k < vt[v].n; k++) q.push_back(vt[v].b[8*(vt[v].n-1-k) +: 8]);
      start_pkt(q, 1000);
      finish_pkt(vt[v].name);
      check({vt[v].name, " table status"}, got_tx.size() == 1 ? {24'h0, got_tx[0]} : 32'hDEAD, {24'h0, vt[v].status});
      check({vt[v].name, " table routes"}, got_routes.size(), vt[v].n_routes);
    end
    check("sync high gap >= 4 clocks", min_gap >= 4, 1'b1);

    // dac_rdy held low: nothing framed until it rises
    dac_rdy = 1'b0;
    q = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
    start_pkt(q, 1000);
    wait_status();
    repeat (200) @(negedge clk);
    check("rdy low no frame", sync_falls, 0);
    dac_rdy = 1'b1;
    finish_pkt("rdy stall");

    // FIFO overflow: five words with rdy low, only four survive
    dac_rdy = 1'b0;
    q = '{8'hDD, 8'h01, 8'h00, 8'h0F};
    s8 = 8'h00;
    for (int k = 1; k <= 15; k++) begin q.push_back(8'(k)); s8 += 8'(k); end
    q.push_back(s8);
    start_pkt(q, 4);
    wait_status();
    dac_rdy = 1'b1;
    finish_pkt("fifo full");

    // Partial word discarded at packet end
    q = '{8'hDD, 8'h01, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'hDD, 8'h01, 8'h00, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h21};
    start_pkt(q, 1000);
    finish_pkt("partial word");

    // Inactivity timeout
    clear_got();
    q = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02};
    send_q(q);
    repeat ((1 << TW) + 300) @(negedge clk);
    check("timeout no status", got_tx.size(), 0);
    check("timeout routed bytes", got_routes.size(), 2);
    q = '{8'hDD, 8'h01, 8'h00, 8'h00, 8'h00};
    start_pkt(q, 1000);
    finish_pkt("after timeout");

    // Bad stop bit is discarded
    rx_pulses = 0;
    send_byte(8'hDD, 1'b0);
    repeat (4 * BAUD) @(negedge clk);
    check("bad stop no rx_valid", rx_pulses, 0);
    start_pkt(q, 1000);
    finish_pkt("after bad stop");
    check("rx_valid count", rx_pulses, 5);

    // Reset mid-packet with a word parked in the FIFO
    clear_got();
    dac_rdy = 1'b0;
    q = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03};
    send_q(q);
    rx = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid reset tx", tx, 1'b1);
    check("mid reset sync", {dac_sync_n, dac_rst_n, dac_sclk}, 3'b100);
    check("mid reset bus", my_valid_bus, '0);
    rx = 1'b1;
    n_rst = 1'b0;
    dac_rdy = 1'b1;
    repeat (300) @(negedge clk);
    check("mid reset no word", got_words.size(), 0);
    check("mid reset no status", got_tx.size(), 0);
    q = '{8'hDD, 8'h01, 8'h00, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h21};
    start_pkt(q, 1000);
    finish_pkt("after mid reset");

    // Random packets against the model
    for (int r = 0; r < 14; r++) begin
      int len;
      q.delete();
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        s8 = 8'($urandom_range(0, 255));
        q.push_back(s8 == 8'hDD ? 8'h55 : s8);
      end
      q.push_back(8'hDD);
      q.push_back(8'($urandom_range(0, 255)));
      q.push_back(8'($urandom_range(0, 5)));
      len = $urandom_range(0, 7);
      q.push_back(8'(len));
      s8 = 8'h00;
      for (int k = 0; k < len; k++) begin
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        s8 += d;
        q.push_back(d);
      end
      q.push_back($urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : s8);
      start_pkt(q, 1000);
      finish_pkt("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
